hex_display_scanner: RTL and testbench

Time-multiplexed driver for the multi-digit hex display. It sits directly upstream of the 4-bit hex-to-7-segment decoder. It captures a 4*DIGITS-bit value (e.g. a register-file word), cycles through its nibbles at a prescaled refresh rate, and feeds one nibble to the decoder. It also drives an active-low one-hot digit select. New values are applied only at frame boundaries (no tearing), and leading zeros can optionally be blanked.

---
 rtl/hex_display_scanner.sv | 122 ++++++++++++
 tb/tb_hex_display_scanner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex display driver: scans a shadowed 4*DIGITS-bit value one
// nibble per prescaled slot, with frame-aligned updates and leading-zero blanking.
module hex_display_scanner #(
  parameter int DIGITS   = 8,
  parameter int PRESCALE = 50000,
  parameter int IDX_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic                  load,
  input  logic                  enable,
  input  logic                  blank_lz,
  output logic [3:0]            nibble_out,
  output logic [DIGITS-1:0]     digit_en_n,
  output logic                  frame_done
);

  localparam int VAL_W = 4 * DIGITS;
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0]  pre_cnt_q,    pre_cnt_d;
  logic [IDX_W-1:0]  idx_q,        idx_d;
  logic [VAL_W-1:0]  shadow_q,     shadow_d;
  logic [VAL_W-1:0]  pend_val_q,   pend_val_d;
  logic              pend_q,       pend_d;
  logic [3:0]        nibble_out_q, nibble_out_d;
  logic [DIGITS-1:0] digit_en_n_q, digit_en_n_d;
  logic              frame_done_q, frame_done_d;

  logic              tick;
  logic              wrap;
  logic [DIGITS-1:0] lz;

  always_comb begin
    tick = enable && (pre_cnt_q == PRE_W'(PRESCALE - 1));
    wrap = tick && (idx_q == IDX_W'(DIGITS - 1));
  end

  // Prescaler and digit index; both freeze while the display is dark.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    idx_d     = idx_q;
    if (tick) begin
      pre_cnt_d = '0;
      idx_d     = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else if (enable) begin
      pre_cnt_d = pre_cnt_q + PRE_W'(1);
    end
    frame_done_d = wrap;
  end

  // Loads while scanning are parked in pend_val and committed on the wrap tick,
  // so a frame never mixes old and new digits.
  always_comb begin
    shadow_d   = shadow_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    if (load) begin
      if (wrap || !enable) begin
        shadow_d = value_in;
        pend_d   = 1'b0;
      end else begin
        pend_val_d = value_in;
        pend_d     = 1'b1;
      end
    end else if (wrap && pend_q) begin
      shadow_d = pend_val_q;
      pend_d   = 1'b0;
    end
  end

  // lz[i]: nibbles i..DIGITS-1 of the shadow are all zero.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz       = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (shadow_q[4*i +: 4] == 4'h0);
      lz[i]    = zero_run;
    end
  end

  always_comb begin
    nibble_out_d = 4'h0;
    digit_en_n_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nibble_out_d = shadow_q[4*i +: 4];
        if (enable && !(blank_lz && lz[i] && (i > 0)))
          digit_en_n_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt_q    <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      pend_val_q   <= '0;
      pend_q       <= 1'b0;
      nibble_out_q <= 4'h0;
      digit_en_n_q <= '1;
      frame_done_q <= 1'b0;
    end else begin
      pre_cnt_q    <= pre_cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      pend_val_q   <= pend_val_d;
      pend_q       <= pend_d;
      nibble_out_q <= nibble_out_d;
      digit_en_n_q <= digit_en_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign nibble_out = nibble_out_q;
  assign digit_en_n = digit_en_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner with PRESCALE=4, DIGITS=8.
module tb_hex_display_scanner;

  localparam int DIGITS   = 8;
  localparam int PRESCALE = 4;
  localparam int IDX_W    = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] value_in;
  logic        load;
  logic        enable;
  logic        blank_lz;
  logic [3:0]  nibble_out;
  logic [7:0]  digit_en_n;
  logic        frame_done;

  int n_vec = 0;
  int n_err = 0;

  hex_display_scanner #(
    .DIGITS   (DIGITS),
    .PRESCALE (PRESCALE),
    .IDX_W    (IDX_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_in   (value_in),
    .load       (load),
    .enable     (enable),
    .blank_lz   (blank_lz),
    .nibble_out (nibble_out),
    .digit_en_n (digit_en_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Checks one full 32-cycle frame starting from idx=0, pre_cnt=0.
  task automatic run_frame(input logic [31:0] val, input logic blz, input string tag);
    for (int c = 0; c < 32; c++) begin
      int         d;
      logic [3:0] nib_exp;
      logic [7:0] en_exp;
      logic       blanked;
      d       = c / 4;
      step(1);
      nib_exp = val[4*d +: 4];
      blanked = blz && (d > 0) && ((val >> (4*d)) == 32'h0);
      en_exp  = blanked ? 8'hFF : ~(8'h01 << d);
      chk($sformatf("%s_nib_c%0d", tag, c), {28'h0, nibble_out}, {28'h0, nib_exp});
      chk($sformatf("%s_en_c%0d", tag, c), {24'h0, digit_en_n}, {24'h0, en_exp});
      chk($sformatf("%s_fd_c%0d", tag, c), {31'h0, frame_done}, {31'h0, (c == 31)});
    end
  endtask

  initial begin
    logic [31:0] cafe;
    cafe     = 32'hCAFE0123;
    rst_n    = 1'b0;
    value_in = 32'h0;
    load     = 1'b0;
    enable   = 1'b0;
    blank_lz = 1'b0;

    // Reset state
    step(2);
    chk("rst_nib", {28'h0, nibble_out}, 32'h0);
    chk("rst_en",  {24'h0, digit_en_n}, 32'hFF);
    chk("rst_fd",  {31'h0, frame_done}, 32'h0);

    // Basic scan: load while dark is immediate, then scan a full frame
    rst_n    = 1'b1;
    load     = 1'b1;
    value_in = 32'h12345678;
    step(1);
    load     = 1'b0;
    chk("dark_en", {24'h0, digit_en_n}, 32'hFF);
    enable   = 1'b1;
    run_frame(32'h12345678, 1'b0, "scan");

    // Mid-frame load is deferred to the frame boundary
    load     = 1'b1;
    value_in = 32'h55555555;
    step(1);
    load     = 1'b0;
    step(31);
    chk("p3_fd", {31'h0, frame_done}, 32'h1);
    step(1);
    chk("p3_nib5", {28'h0, nibble_out}, 32'h5);
    chk("p3_en0",  {24'h0, digit_en_n}, 32'hFE);
    step(13);
    load     = 1'b1;
    value_in = 32'hAAAAAAAA;
    step(1);
    load     = 1'b0;
    step(2);
    for (int d = 4; d < 8; d++) begin
      chk($sformatf("p3_keep_nib_d%0d", d), {28'h0, nibble_out}, 32'h5);
      chk($sformatf("p3_keep_en_d%0d", d), {24'h0, digit_en_n}, {24'h0, ~(8'h01 << d)});
      if (d < 7) step(4);
    end
    step(3);
    chk("p3_wrap_fd",  {31'h0, frame_done}, 32'h1);
    chk("p3_wrap_nib", {28'h0, nibble_out}, 32'h5);
    step(1);
    chk("p3_new_nib", {28'h0, nibble_out}, 32'hA);
    chk("p3_new_en",  {24'h0, digit_en_n}, 32'hFE);
    chk("p3_new_fd",  {31'h0, frame_done}, 32'h0);

    // Load on the wrap tick beats an older pending value
    load     = 1'b1;
    value_in = 32'h11111111;
    step(1);
    load     = 1'b0;
    step(29);
    load     = 1'b1;
    value_in = cafe;
    step(1);
    load     = 1'b0;
    chk("p4_fd", {31'h0, frame_done}, 32'h1);
    step(1);
    for (int d = 0; d < 8; d++) begin
      chk($sformatf("p4_nib_d%0d", d), {28'h0, nibble_out}, {28'h0, cafe[4*d +: 4]});
      step(4);
    end
    chk("p4_no_stale_nib", {28'h0, nibble_out}, 32'h3);
    chk("p4_no_stale_en",  {24'h0, digit_en_n}, 32'hFE);

    // Disable at idx=5 holds counters; load while dark applies at once
    step(21);
    chk("p5_pre_nib", {28'h0, nibble_out}, 32'hF);
    chk("p5_pre_en",  {24'h0, digit_en_n}, 32'hDF);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        load     = 1'b1;
        value_in = 32'h76543210;
      end
      if (i == 5) load = 1'b0;
      step(1);
      chk($sformatf("p5_dark_en_%0d", i), {24'h0, digit_en_n}, 32'hFF);
      chk($sformatf("p5_dark_fd_%0d", i), {31'h0, frame_done}, 32'h0);
    end
    chk("p5_dark_nib", {28'h0, nibble_out}, 32'h5);
    enable = 1'b1;
    step(1);
    chk("p5_res_en_a",  {24'h0, digit_en_n}, 32'hDF);
    chk("p5_res_nib_a", {28'h0, nibble_out}, 32'h5);
    step(1);
    chk("p5_res_en_b",  {24'h0, digit_en_n}, 32'hDF);
    step(1);
    chk("p5_res_en_c",  {24'h0, digit_en_n}, 32'hBF);
    chk("p5_res_nib_c", {28'h0, nibble_out}, 32'h6);

    // Reset mid-scan at idx=6
    rst_n = 1'b0;
    step(1);
    chk("p6_rst_en",  {24'h0, digit_en_n}, 32'hFF);
    chk("p6_rst_nib", {28'h0, nibble_out}, 32'h0);
    chk("p6_rst_fd",  {31'h0, frame_done}, 32'h0);
    rst_n = 1'b1;
    step(1);
    chk("p6_d0_en",  {24'h0, digit_en_n}, 32'hFE);
    chk("p6_d0_nib", {28'h0, nibble_out}, 32'h0);
    step(4);
    chk("p6_d1_en",  {24'h0, digit_en_n}, 32'hFD);
    chk("p6_d1_nib", {28'h0, nibble_out}, 32'h0);

    // Leading-zero blanking
    rst_n = 1'b0;
    step(1);
    rst_n    = 1'b1;
    enable   = 1'b0;
    blank_lz = 1'b1;
    load     = 1'b1;
    value_in = 32'h00000A3F;
    step(1);
    load     = 1'b0;
    enable   = 1'b1;
    run_frame(32'h00000A3F, 1'b1, "blz");
    load     = 1'b1;
    value_in = 32'h0;
    step(1);
    load     = 1'b0;
    step(31);
    chk("blz0_fd", {31'h0, frame_done}, 32'h1);
    run_frame(32'h0, 1'b1, "blz0");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
